serial_pattern_tx: RTL

- Serial bit-stream transmitter: takes a parallel pattern of 1–8 bits and drives it MSB-first, one bit per `step` strobe, on a single serial line.
- Transmit end of the single-bit `w` stream consumed by the team's sequence-detector FSMs. The detector's input bit can come from this block instead of a slide switch, and known patterns (e.g. 1101, 1111) can be replayed deterministically.
- Exposes its state code for LEDR display.

---
 rtl/serial_pattern_tx.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx
//   Serial bit-stream transmitter. A parallel pattern of 1..MAX_LEN bits is
//   shifted out MSB-first (bit `length` first, bit 0 last), one bit per
//   `step_i` strobe, on the single-bit line `w_o`. It feeds the `w` input of
//   the sequence-detector FSMs, so known patterns can be replayed
//   deterministically.
//
//   Optional feature macro: SEQGEN_REPEAT_EN
//     defined   : `reps_i` is honoured. Repetitions are separated by one GAP
//                 bit-time with w_valid_o = 0. `done_o` pulses once, after the
//                 last repetition.
//     undefined : `reps_i` is ignored. No rep counter and no GAP state are
//                 built, and code 3 is handled like any other illegal code.
//
// Ports
//   clock_i     rising-edge clock
//   resetn_i    asynchronous active-low reset
//   start_i     transmit request, sampled only in IDLE
//   pattern_i   bits to send
//   length_i    pattern length minus one
//   reps_i      repetition count, 0 treated as 1 (repeat build only)
//   step_i      bit-advance strobe
//   w_o         serial output bit
//   w_valid_o   high while w_o carries a pattern bit
//   busy_o      high in every state except IDLE
//   done_o      one-cycle pulse at the end of a transmission
//   state_o     current state code, for the LEDR display
module serial_pattern_tx #(
    parameter int MAX_LEN = 8
) (
    input  logic                       clock_i,
    input  logic                       resetn_i,
    input  logic                       start_i,
    input  logic [MAX_LEN-1:0]         pattern_i,
    input  logic [$clog2(MAX_LEN)-1:0] length_i,
    input  logic [3:0]                 reps_i,
    input  logic                       step_i,
    output logic                       w_o,
    output logic                       w_valid_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [2:0]                 state_o
);

    localparam int IDX_W = $clog2(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SEND = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Shadow copy of the frame. After LOAD the inputs are free to change.
    typedef struct packed {
        logic [MAX_LEN-1:0] pat;
        logic [IDX_W-1:0]   len;
    } shadow_t;

    state_t           state_q, state_d;
    shadow_t          shd_q, shd_d;
    logic [IDX_W-1:0] idx_q, idx_d;

`ifdef SEQGEN_REPEAT_EN
    logic [3:0]       rep_q, rep_d;
`else
    logic             unused_reps;
    assign unused_reps = ^reps_i;
`endif

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= S_IDLE;
            shd_q   <= '0;
            idx_q   <= '0;
`ifdef SEQGEN_REPEAT_EN
            rep_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            shd_q   <= shd_d;
            idx_q   <= idx_d;
`ifdef SEQGEN_REPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        shd_d   = shd_q;
        idx_d   = idx_q;
`ifdef SEQGEN_REPEAT_EN
        rep_d   = rep_q;
`endif
        case (state_q)
            S_IDLE: begin
                // start wins over step; step has no meaning here
                if (start_i) state_d = S_LOAD;
            end
            S_LOAD: begin
                shd_d.pat = pattern_i;
                shd_d.len = length_i;
                idx_d     = length_i;
`ifdef SEQGEN_REPEAT_EN
                rep_d     = (reps_i == 4'd0) ? 4'd1 : reps_i;
`endif
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (step_i) begin
                    if (idx_q != '0) begin
                        idx_d = idx_q - 1'b1;
                    end else begin
`ifdef SEQGEN_REPEAT_EN
                        state_d = (rep_q > 4'd1) ? S_GAP : S_DONE;
`else
                        state_d = S_DONE;
`endif
                    end
                end
            end
`ifdef SEQGEN_REPEAT_EN
            S_GAP: begin
                if (step_i) begin
                    // counter floor is 1; GAP is only entered with rep_q > 1
                    if (rep_q > 4'd1) rep_d = rep_q - 4'd1;
                    idx_d   = shd_q.len;
                    state_d = S_SEND;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                // unused codes recover to IDLE
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are a pure decode of registered state and shadow contents.
    assign busy_o    = (state_q != S_IDLE);
    assign w_valid_o = (state_q == S_SEND);
    assign w_o       = w_valid_o & shd_q.pat[idx_q];
    assign done_o    = (state_q == S_DONE);
    assign state_o   = state_q;

endmodule
